// File: rtl/pixy_bus_pkg.sv
// Shared types and memory-map constants for the Pixy-68000 bus cycle logic.
package pixy_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACK,
    HANG,
    ERR
  } bus_state_e;

  typedef enum logic [1:0] {
    REG_PROM,
    REG_SRAM,
    REG_NONE
  } region_e;

  localparam logic [3:0] PROM_NIBBLE = 4'h0;
  localparam logic [3:0] SRAM_NIBBLE = 4'h1;

endpackage

// File: rtl/bus_region_decode.sv
// Memory map: A23..A20 and RW to region. PROM is read-only, so a
// PROM write decodes as unmapped.
module bus_region_decode
  import pixy_bus_pkg::*;
(
  input  logic [3:0] addr_nib,
  input  logic       rw,
  output region_e    region
);

  logic prom_hit;
  logic sram_hit;

  assign prom_hit = (addr_nib == PROM_NIBBLE) && rw;
  assign sram_hit = (addr_nib == SRAM_NIBBLE);

  always_comb begin
    region = REG_NONE;
    unique case (1'b1)
      prom_hit: region = REG_PROM;
      sram_hit: region = REG_SRAM;
      default:  region = REG_NONE;
    endcase
  end

endmodule

// File: rtl/bus_cycle_controller.sv
// 68000 bus cycle sequencer: decode, wait states, DTACK, optional
// watchdog BERR (enabled by defining BUS_WATCHDOG_EN).
module bus_cycle_controller
  import pixy_bus_pkg::*;
#(
  parameter int PROM_WAIT  = 2,
  parameter int SRAM_WAIT  = 0,
  parameter int WDT_CYCLES = 64
) (
  input  logic        CPUCLK_IN,
  input  logic        RESET_IN,
  input  logic        AS_IN,
  input  logic        UDS_IN,
  input  logic        LDS_IN,
  input  logic        RW_IN,
  input  logic [23:0] ADDR_IN,
  output logic        PROMCS0,
  output logic        PROMCS1,
  output logic        SRAMCS0,
  output logic        SRAMCS1,
  output logic        OE,
  output logic        WE,
  output logic        DTACK,
  output logic        BERR
);

  bus_state_e state_q, state_d;
  region_e    region_q, region_d;
  region_e    region;
  region_e    sel_region;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] load_cnt;
  logic       cs0_q, cs0_d;
  logic       cs1_q, cs1_d;
  logic       oe_q, oe_d;
  logic       we_q, we_d;
  logic       dtack_q, dtack_d;
  logic       berr_q, berr_d;
  logic       wdt_hit;
  logic       unused_addr_lo;

  assign unused_addr_lo = ^ADDR_IN[19:0];

  bus_region_decode u_decode (
    .addr_nib (ADDR_IN[23:20]),
    .rw       (RW_IN),
    .region   (region)
  );

  assign load_cnt = (region == REG_PROM) ? 4'(PROM_WAIT)
                                         : 4'(SRAM_WAIT);

  // Strobe decode uses the fresh region on the accepting edge.
  assign sel_region = (state_q == IDLE) ? region : region_q;

`ifdef BUS_WATCHDOG_EN
  logic [7:0] wdt_q, wdt_d;

  always_comb begin
    wdt_d = wdt_q;
    if (state_q == IDLE) begin
      wdt_d = '0;
    end else if (AS_IN && (state_q == WAIT || state_q == HANG)) begin
      wdt_d = wdt_q + 8'd1;
    end
  end

  assign wdt_hit = AS_IN && ((wdt_q + 8'd1) == 8'(WDT_CYCLES));

  always_ff @(posedge CPUCLK_IN or posedge RESET_IN) begin
    if (RESET_IN) wdt_q <= '0;
    else          wdt_q <= wdt_d;
  end
`else
  logic [7:0] unused_wdt;
  assign unused_wdt = 8'(WDT_CYCLES);
  assign wdt_hit    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    cnt_d    = cnt_q;
    cs0_d    = 1'b0;
    cs1_d    = 1'b0;
    oe_d     = 1'b0;
    we_d     = 1'b0;
    dtack_d  = 1'b0;
    berr_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (AS_IN) begin
          region_d = region;
          cnt_d    = load_cnt;
          if (region == REG_NONE) begin
            state_d = HANG;
          end else begin
            state_d = WAIT;
            cs0_d   = UDS_IN;
            cs1_d   = LDS_IN;
            oe_d    = RW_IN;
            we_d    = ~RW_IN && (sel_region == REG_SRAM);
          end
        end
      end
      WAIT: begin
        if (!AS_IN) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ACK;
          dtack_d = 1'b1;
          cs0_d   = UDS_IN;
          cs1_d   = LDS_IN;
          oe_d    = RW_IN;
          we_d    = ~RW_IN && (sel_region == REG_SRAM);
        end else if (wdt_hit) begin
          state_d = ERR;
          berr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
          cs0_d = UDS_IN;
          cs1_d = LDS_IN;
          oe_d  = RW_IN;
          we_d  = ~RW_IN && (sel_region == REG_SRAM);
        end
      end
      ACK: begin
        if (!AS_IN) begin
          state_d = IDLE;
        end else begin
          dtack_d = 1'b1;
          cs0_d   = UDS_IN;
          cs1_d   = LDS_IN;
          oe_d    = RW_IN;
          we_d    = ~RW_IN && (sel_region == REG_SRAM);
        end
      end
      HANG: begin
        if (!AS_IN) begin
          state_d = IDLE;
        end else if (wdt_hit) begin
          state_d = ERR;
          berr_d  = 1'b1;
        end
      end
      ERR: begin
        if (!AS_IN) state_d = IDLE;
        else        berr_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) region_d = REG_NONE;
  end

  always_ff @(posedge CPUCLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      state_q  <= IDLE;
      region_q <= REG_NONE;
      cnt_q    <= '0;
      cs0_q    <= 1'b0;
      cs1_q    <= 1'b0;
      oe_q     <= 1'b0;
      we_q     <= 1'b0;
      dtack_q  <= 1'b0;
      berr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      cnt_q    <= cnt_d;
      cs0_q    <= cs0_d;
      cs1_q    <= cs1_d;
      oe_q     <= oe_d;
      we_q     <= we_d;
      dtack_q  <= dtack_d;
      berr_q   <= berr_d;
    end
  end

  assign PROMCS0 = cs0_q && (region_q == REG_PROM);
  assign PROMCS1 = cs1_q && (region_q == REG_PROM);
  assign SRAMCS0 = cs0_q && (region_q == REG_SRAM);
  assign SRAMCS1 = cs1_q && (region_q == REG_SRAM);
  assign OE      = oe_q;
  assign WE      = we_q;
  assign DTACK   = dtack_q;
  assign BERR    = berr_q;

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Randomized scoreboard bench for bus_cycle_controller against a
// cycle-offset reference model of the bus protocol.
module tb_bus_cycle_controller;

  localparam int PW  = 2;
  localparam int SW  = 0;
  localparam int WDT = 64;
`ifdef BUS_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        as_i = 1'b0;
  logic        uds = 1'b0;
  logic        lds = 1'b0;
  logic        rw = 1'b1;
  logic [23:0] addr = '0;
  logic        pcs0, pcs1, scs0, scs1, oe, we, dtack, berr;

  bus_cycle_controller #(
    .PROM_WAIT  (PW),
    .SRAM_WAIT  (SW),
    .WDT_CYCLES (WDT)
  ) dut (
    .CPUCLK_IN (clk),
    .RESET_IN  (rst),
    .AS_IN     (as_i),
    .UDS_IN    (uds),
    .LDS_IN    (lds),
    .RW_IN     (rw),
    .ADDR_IN   (addr),
    .PROMCS0   (pcs0),
    .PROMCS1   (pcs1),
    .SRAMCS0   (scs0),
    .SRAMCS1   (scs1),
    .OE        (oe),
    .WE        (we),
    .DTACK     (dtack),
    .BERR      (berr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb[$];

  function automatic logic [7:0] outs();
    return {pcs0, pcs1, scs0, scs1, oe, we, dtack, berr};
  endfunction

  // Reference model: a bus cycle is tracked as "cycles since acceptance".
  bit m_busy = 1'b0;
  int m_k    = 0;
  int m_reg  = 2;
  bit m_rw   = 1'b1;

  task automatic model_step(input logic a_s, input logic u, input logic l,
                            input logic r, input logic [23:0] a,
                            output logic [7:0] e);
    logic [3:0] nib;
    bit dt;
    nib = a[23:20];
    e = 8'h00;
    if (!m_busy) begin
      if (a_s) begin
        m_busy = 1'b1;
        m_k    = 0;
        m_rw   = r;
        if (nib == 4'h0 && r) m_reg = 0;
        else if (nib == 4'h1) m_reg = 1;
        else m_reg = 2;
      end
    end else if (!a_s) begin
      m_busy = 1'b0;
    end else begin
      m_k++;
    end
    if (m_busy && a_s) begin
      dt = (m_k >= ((m_reg == 0) ? PW : SW) + 1);
      if (m_reg == 0)
        e = {u, l, 2'b00, m_rw, 1'b0, dt, 1'b0};
      else if (m_reg == 1)
        e = {2'b00, u, l, m_rw, ~m_rw, dt, 1'b0};
      else
        e = {7'b0, WD && (m_k >= WDT)};
    end
  endtask

  task automatic cycle(input logic a_s, input logic u, input logic l,
                       input logic r, input logic [23:0] a);
    logic [7:0] e;
    as_i = a_s; uds = u; lds = l; rw = r; addr = a;
    model_step(a_s, u, l, r, a, e);
    @(posedge clk);
    #1;
    sb.push_back(e);
  endtask

  task automatic txn(input logic [23:0] a, input logic r, input int hold,
                     input logic u, input logic l, input bit rnd,
                     input int gap);
    logic [1:0] s;
    for (int i = 0; i < hold; i++) begin
      s = {u, l};
      if (rnd) s = 2'($urandom_range(1, 3));
      cycle(1'b1, s[1], s[0], r, a);
    end
    for (int i = 0; i < gap; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 24'h0);
  endtask

  task automatic check_now(input string name, input logic [7:0] e);
    total++;
    if (outs() !== e) begin
      bad++;
      $display("FAIL %s got=%b exp=%b t=%0t", name, outs(), e, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (outs() !== e) begin
        bad++;
        $display("FAIL cycle_outs got=%b exp=%b t=%0t", outs(), e, $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] a;
    logic        r;
    int          sel;
    int          hold;
    #3;
    check_now("reset_state", 8'h00);
    #9;
    rst = 1'b0;
    @(posedge clk);
    #1;
    txn(24'h000004, 1'b1, 6, 1'b1, 1'b1, 1'b0, 2);
    txn(24'h100001, 1'b0, 3, 1'b0, 1'b1, 1'b0, 2);
    txn(24'h000010, 1'b0, 70, 1'b1, 1'b1, 1'b0, 2);
    txn(24'h300000, 1'b1, 5, 1'b1, 1'b1, 1'b0, 1);
    txn(24'h100000, 1'b1, 3, 1'b1, 1'b1, 1'b0, 2);
    txn(24'h000008, 1'b1, 2, 1'b1, 1'b1, 1'b0, 0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_now("async_reset", 8'h00);
    m_busy = 1'b0;
    as_i = 1'b0;
    uds = 1'b0;
    lds = 1'b0;
    @(posedge clk);
    #3;
    check_now("reset_hold", 8'h00);
    rst = 1'b0;
    txn(24'h000000, 1'b1, 0, 1'b0, 1'b0, 1'b0, 3);
    txn(24'h000020, 1'b1, 2, 1'b1, 1'b0, 1'b0, 1);
    txn(24'h100002, 1'b1, 3, 1'b1, 1'b1, 1'b0, 2);
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 3);
      a = 24'($urandom);
      r = 1'($urandom);
      if (sel == 0) a[23:20] = 4'h0;
      else if (sel == 1 || sel == 2) a[23:20] = 4'h1;
      else a[23:20] = 4'($urandom_range(2, 15));
      hold = $urandom_range(1, 8);
      txn(a, r, hold, 1'b1, 1'b1, 1'b1, $urandom_range(1, 3));
    end
    @(negedge clk);
    #2;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain got=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
